// File: rtl/mat_switch.sv
`default_nettype none
// ======================================================================================
// mat_switch: N x N inter-core mailbox switch, one message slot per (source, destination).
// Rev 1.0
// ======================================================================================
module mat_switch #(
  parameter  int SWITCH_WIDTH          = 16,
  parameter  int SWITCH_CORE_SIZE      = 4,
  localparam int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic [SWITCH_CORE_SIZE-1:0]                           send_ready_i,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] send_core_idx_i,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]   send_data_i,
  output logic [SWITCH_CORE_SIZE-1:0]                           send_ok_o,
  input  logic [SWITCH_CORE_SIZE-1:0]                           recv_request_i,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] recv_core_idx_i,
  output logic [SWITCH_CORE_SIZE-1:0]                           recv_ready_o,
  output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]   recv_data_o,
  output logic [$clog2(SWITCH_CORE_SIZE*SWITCH_CORE_SIZE+1)-1:0] pending_count_o
);

  localparam int N  = SWITCH_CORE_SIZE;
  localparam int SW = SWITCH_WIDTH;
  localparam int AW = SWITCH_CORE_ADDR_SIZE;
  localparam int CW = $clog2(N*N+1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_DELIVER = 1'b1
  } rx_state_e;

  typedef logic [SW-1:0][31:0] msg_t;

  // Slot arrays are indexed [source][destination]; elements are IEEE-754 single bit patterns.
  logic [N-1:0][N-1:0] slot_full_q, slot_full_d;
  msg_t                slot_data_q [N][N];
  rx_state_e           state_q [N];
  logic [N-1:0]        recv_ready_q;
  logic [N-1:0][SW-1:0][31:0] recv_data_q;
  logic [CW-1:0]       pending_q, pending_d;

  logic [N-1:0][N-1:0] drain;
  logic [N-1:0][N-1:0] wr;
  logic [N-1:0]        rx_hit;
  logic [N-1:0]        send_ok;

  always_comb begin
    drain  = '0;
    rx_hit = '0;
    for (int d = 0; d < N; d++) begin
      rx_hit[d] = (state_q[d] == ST_IDLE) && recv_request_i[d] &&
                  slot_full_q[recv_core_idx_i[d]][d];
      for (int s = 0; s < N; s++) begin
        drain[s][d] = rx_hit[d] && (recv_core_idx_i[d] == AW'(s));
      end
    end
  end

  // A slot being drained this cycle can be refilled at the same edge.
  always_comb begin
    send_ok = '0;
    wr      = '0;
    for (int s = 0; s < N; s++) begin
      send_ok[s] = !slot_full_q[s][send_core_idx_i[s]] || drain[s][send_core_idx_i[s]];
      for (int d = 0; d < N; d++) begin
        wr[s][d] = send_ready_i[s] && send_ok[s] && (send_core_idx_i[s] == AW'(d));
      end
    end
  end

  always_comb begin
    slot_full_d = (slot_full_q & ~drain) | wr;
    pending_d   = pending_q;
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        if (wr[s][d] && !slot_full_q[s][d]) begin
          pending_d = pending_d + CW'(1);
        end else if (drain[s][d] && !wr[s][d]) begin
          pending_d = pending_d - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_full_q  <= '0;
      pending_q    <= '0;
      recv_ready_q <= '0;
      recv_data_q  <= '0;
      for (int d = 0; d < N; d++) begin
        state_q[d] <= ST_IDLE;
      end
    end else begin
      slot_full_q <= slot_full_d;
      pending_q   <= pending_d;
      for (int d = 0; d < N; d++) begin
        recv_ready_q[d] <= 1'b0;
        case (state_q[d])
          ST_IDLE: begin
            if (rx_hit[d]) begin
              recv_ready_q[d] <= 1'b1;
              recv_data_q[d]  <= slot_data_q[recv_core_idx_i[d]][d];
              state_q[d]      <= ST_DELIVER;
            end
          end
          ST_DELIVER: state_q[d] <= ST_IDLE;
          default:    state_q[d] <= ST_IDLE;
        endcase
      end
    end
  end

  // Payload storage is qualified by slot_full_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        if (wr[s][d]) begin
          slot_data_q[s][d] <= send_data_i[s];
        end
      end
    end
  end

  assign send_ok_o       = send_ok;
  assign recv_ready_o    = recv_ready_q;
  assign recv_data_o     = recv_data_q;
  assign pending_count_o = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_mat_switch.sv
`default_nettype none
// ======================================================================================
// tb_mat_switch: vector table plus hand sequences, deliveries checked through a scoreboard.
// Rev 1.0
// ======================================================================================
module tb_mat_switch;

  typedef logic [15:0][31:0] pay_t;
  typedef struct {
    int   d;
    pay_t data;
  } exp_t;

  typedef struct packed {
    logic [3:0][9:0] sb;
    logic [3:0][1:0] sd;
    logic [3:0]      rq;
    logic [3:0][1:0] rs;
    logic [3:0]      ok;
    logic [4:0]      cnt;
    logic [3:0][9:0] dl;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [3:0]       send_ready;
  logic [3:0][1:0]  send_idx;
  logic [3:0][15:0][31:0] send_data;
  logic [3:0]       send_ok;
  logic [3:0]       recv_request;
  logic [3:0][1:0]  recv_idx;
  logic [3:0]       recv_ready;
  logic [3:0][15:0][31:0] recv_data;
  logic [4:0]       pending;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];
  vec_t vecs[9];

  mat_switch #(.SWITCH_WIDTH(16), .SWITCH_CORE_SIZE(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .send_ready_i    (send_ready),
    .send_core_idx_i (send_idx),
    .send_data_i     (send_data),
    .send_ok_o       (send_ok),
    .recv_request_i  (recv_request),
    .recv_core_idx_i (recv_idx),
    .recv_ready_o    (recv_ready),
    .recv_data_o     (recv_data),
    .pending_count_o (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f32(int v);
    int e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'(v << (23 - e))};
  endfunction

  function automatic pay_t mk(int base);
    pay_t p;
    for (int k = 0; k < 16; k++) p[k] = f32(base + k);
    return p;
  endfunction

  function automatic pay_t mk35();
    pay_t p;
    for (int k = 0; k < 16; k++) p[k] = 32'h4060_0000;
    return p;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    send_ready   = '0;
    send_idx     = '0;
    send_data    = '0;
    recv_request = '0;
    recv_idx     = '0;
  endtask

  task automatic send(int c, int d, pay_t p);
    send_ready[c] = 1'b1;
    send_idx[c]   = 2'(d);
    send_data[c]  = p;
  endtask

  task automatic req(int d, int s);
    recv_request[d] = 1'b1;
    recv_idx[d]     = 2'(s);
  endtask

  task automatic expect_rx(int d, pay_t p);
    exp_t e;
    e.d    = d;
    e.data = p;
    exp_q.push_back(e);
  endtask

  // Delivery monitor: every recv_ready pulse must match the oldest expectation for that core.
  always @(posedge clk) begin
    int idx;
    #1;
    if (mon_en) begin
      for (int d = 0; d < 4; d++) begin
        if (recv_ready[d] === 1'b1) begin
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].d == d && idx < 0) idx = j;
          end
          n_checks++;
          if (idx < 0) begin
            n_fail++;
            $display("FAIL unexpected delivery to core %0d: got %h expected no pulse", d, recv_data[d]);
          end else begin
            if (recv_data[d] !== exp_q[idx].data) begin
              n_fail++;
              $display("FAIL core%0d payload: got %h expected %h", d, recv_data[d], exp_q[idx].data);
            end
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    bit [5:0] acc_pat;
    bit [5:0] dlv_pat;
    int       k;
    int       nd;
    logic [3:0] rmask;

    vecs[0] = '{sb: {10'd448, 10'd432, 10'd416, 10'd400}, sd: {2'd1, 2'd2, 2'd0, 2'd1},
                rq: 4'b0000, rs: '0, ok: 4'b1111, cnt: 5'd4, dl: '0};
    vecs[1] = '{sb: '0, sd: '0, rq: 4'b0010, rs: '0, ok: 4'b1101, cnt: 5'd3,
                dl: {10'd0, 10'd0, 10'd400, 10'd0}};
    vecs[2] = '{sb: '0, sd: '0, rq: 4'b0010, rs: {2'd0, 2'd0, 2'd3, 2'd0}, ok: 4'b1101,
                cnt: 5'd3, dl: '0};
    vecs[3] = '{sb: '0, sd: '0, rq: 4'b0010, rs: {2'd0, 2'd0, 2'd3, 2'd0}, ok: 4'b1101,
                cnt: 5'd2, dl: {10'd0, 10'd0, 10'd448, 10'd0}};
    vecs[4] = '{sb: {10'd464, 10'd0, 10'd0, 10'd0}, sd: {2'd1, 2'd0, 2'd0, 2'd0},
                rq: 4'b0101, rs: {2'd0, 2'd2, 2'd0, 2'd1}, ok: 4'b1111, cnt: 5'd1,
                dl: {10'd0, 10'd432, 10'd0, 10'd416}};
    vecs[5] = '{sb: {10'd480, 10'd0, 10'd0, 10'd0}, sd: {2'd1, 2'd0, 2'd0, 2'd0},
                rq: 4'b0010, rs: {2'd0, 2'd0, 2'd3, 2'd0}, ok: 4'b1111, cnt: 5'd1,
                dl: {10'd0, 10'd0, 10'd464, 10'd0}};
    vecs[6] = '{sb: '0, sd: '0, rq: 4'b0010, rs: {2'd0, 2'd0, 2'd3, 2'd0}, ok: 4'b1111,
                cnt: 5'd1, dl: '0};
    vecs[7] = '{sb: '0, sd: '0, rq: 4'b0010, rs: {2'd0, 2'd0, 2'd3, 2'd0}, ok: 4'b1111,
                cnt: 5'd0, dl: {10'd0, 10'd0, 10'd480, 10'd0}};
    vecs[8] = '{sb: '0, sd: '0, rq: 4'b0000, rs: '0, ok: 4'b1111, cnt: 5'd0, dl: '0};

    // Reset asserted mid-cycle, then released mid-cycle.
    rst_n = 1'b1;
    clear();
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("reset recv_ready", recv_ready, 4'b0000);
    chk("reset pending", pending, 5'd0);
    chk("reset send_ok", send_ok, 4'b1111);
    chk("reset recv_data", recv_data[0][0] | recv_data[3][15], 32'h0);
    mon_en = 1'b1;
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle recv_ready", recv_ready, 4'b0000);
    end
    chk("idle pending", pending, 5'd0);

    // Basic transfer 0 -> 2.
    clear();
    send(0, 2, mk(1));
    #1 chk("basic send_ok", send_ok[0], 1'b1);
    step();
    chk("basic pending after send", pending, 5'd1);
    clear();
    req(2, 0);
    expect_rx(2, mk(1));
    step();
    chk("basic recv_ready", recv_ready, 4'b0100);
    chk("basic pending after recv", pending, 5'd0);
    clear();
    step();
    chk("basic pulse width", recv_ready, 4'b0000);

    // Backpressure on slot 1 -> 3.
    clear();
    send(1, 3, mk35());
    #1 chk("bp first send_ok", send_ok[1], 1'b1);
    step();
    chk("bp pending", pending, 5'd1);
    clear();
    send(1, 3, mk(200));
    #1 chk("bp stall send_ok", send_ok[1], 1'b0);
    step();
    chk("bp pending stalled", pending, 5'd1);
    #1 chk("bp still stalled", send_ok[1], 1'b0);
    step();
    req(3, 1);
    expect_rx(3, mk35());
    #1 chk("bp accept on drain", send_ok[1], 1'b1);
    step();
    chk("bp recv_ready", recv_ready, 4'b1000);
    chk("bp pending refill", pending, 5'd1);
    clear();
    req(3, 1);
    step();
    chk("bp deliver ignores req", recv_ready, 4'b0000);
    chk("bp pending held", pending, 5'd1);
    clear();
    req(3, 1);
    expect_rx(3, mk(200));
    step();
    chk("bp second recv_ready", recv_ready, 4'b1000);
    chk("bp pending empty", pending, 5'd0);
    clear();
    step();

    // Held request from core 2 while core 0 offers a new message every cycle.
    acc_pat = 6'b101011;
    dlv_pat = 6'b101010;
    k  = 0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      clear();
      send(0, 2, mk(300 + k));
      req(2, 0);
      if (dlv_pat[i]) begin
        expect_rx(2, mk(300 + nd));
        nd++;
      end
      #1 chk($sformatf("held send_ok c%0d", i), send_ok[0], acc_pat[i]);
      step();
      chk($sformatf("held recv_ready c%0d", i), recv_ready[2], dlv_pat[i]);
      chk($sformatf("held pending c%0d", i), pending, 5'd1);
      if (acc_pat[i]) k++;
    end
    clear();
    step();
    req(2, 0);
    expect_rx(2, mk(303));
    step();
    chk("held last recv_ready", recv_ready, 4'b0100);
    chk("held pending empty", pending, 5'd0);
    clear();
    step();

    // Crossed traffic vector table.
    for (int i = 0; i < 9; i++) begin
      clear();
      rmask = '0;
      for (int c = 0; c < 4; c++) begin
        if (vecs[i].sb[c] != 0) send(c, int'(vecs[i].sd[c]), mk(int'(vecs[i].sb[c])));
        if (vecs[i].dl[c] != 0) begin
          expect_rx(c, mk(int'(vecs[i].dl[c])));
          rmask[c] = 1'b1;
        end
      end
      recv_request = vecs[i].rq;
      recv_idx     = vecs[i].rs;
      #1 chk($sformatf("vec%0d send_ok", i), send_ok, vecs[i].ok);
      step();
      chk($sformatf("vec%0d pending", i), pending, vecs[i].cnt);
      chk($sformatf("vec%0d recv_ready", i), recv_ready, rmask);
    end

    // Asynchronous reset while three slots are full and core 0 is delivering.
    clear();
    send(1, 0, mk(500));
    send(2, 3, mk(516));
    send(3, 3, mk(532));
    send(0, 2, mk(548));
    step();
    chk("ar pending full", pending, 5'd4);
    clear();
    req(0, 1);
    expect_rx(0, mk(500));
    step();
    chk("ar deliver pulse", recv_ready, 4'b0001);
    chk("ar pending before", pending, 5'd3);
    clear();
    #2 rst_n = 1'b0;
    #1;
    chk("ar recv_ready async drop", recv_ready, 4'b0000);
    chk("ar pending cleared", pending, 5'd0);
    chk("ar send_ok", send_ok, 4'b1111);
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      clear();
      req(3, 2);
      req(2, 0);
      req(1, 3);
      step();
      chk("ar no stale delivery", recv_ready, 4'b0000);
      chk("ar pending stays 0", pending, 5'd0);
    end
    clear();
    step();

    chk("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mat_switch.md
# mat_switch

Inter-core message switch for the MatCore array. It sits directly on each MatCore's switch send/recv ports and moves one vector of SWITCH_WIDTH shortreal values from a sending core to a named receiving core. Buffering is one mailbox slot per (source, destination) pair. Senders complete without waiting for the receiver, and receivers pull data by naming the source core.

## Interface
- SWITCH_WIDTH, 16: shortreal elements per message.
- SWITCH_CORE_SIZE, 4: number of attached cores (N); power of two, ≥ 2.
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE): core index width (derived).

Ports. Arrays are indexed [SWITCH_CORE_SIZE-1:0] by core; data arrays are additionally [SWITCH_WIDTH-1:0].
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- send_ready  in  [N]  core c offers a message.
- send_core_idx  in  [N][ADDR]  destination of core c's message.
- send_data  in  shortreal [N][SW]  payload of core c's message.
- send_ok  out  [N]  combinational accept for core c; write happens at the edge closing any cycle with send_ready && send_ok.
- recv_request  in  [N]  core c wants a message.
- recv_core_idx  in  [N][ADDR]  source core c wants to receive from.
- recv_ready  out  [N]  registered one-cycle delivery pulse to core c.
- recv_data  out  shortreal [N][SW]  registered payload; valid when recv_ready.
- pending_count  out  [$clog2(N*N+1)]  registered number of full slots.

## Operation
- State:
  - slot_full[s][d] and slot_data[s][d][SW] for every ordered pair, including s == d.
  - Per receiver, a 2-state FSM: IDLE / DELIVER.
- Send path, core s targeting d = send_core_idx[s]:
  - send_ok[s] = !slot_full[s][d] || drain[s][d], where drain is this cycle's receive of that slot.
  - On accept: slot_data ← send_data[s] and slot_full ← 1.
  - send_ok may be high while send_ready is low; it has no effect then.
- Receive path, core d naming s = recv_core_idx[d]:
  - drain[s][d] = FSM[d] == IDLE && recv_request[d] && slot_full[s][d].
  - On drain: recv_data[d] ← slot_data[s][d], recv_ready[d] ← 1, slot_full[s][d] ← 0 unless refilled the same edge, FSM[d] → DELIVER.
- DELIVER lasts exactly one cycle and always returns to IDLE.
  - recv_request is ignored during DELIVER, so a receiver holding request through the recv_ready cycle cannot double-receive.
- Simultaneous drain and write of the same slot:
  - The receiver gets the old data.
  - The slot holds the new data, full = 1.
  - pending_count is unchanged.
- Each core has a single send and a single receive port, so at most one write and one drain per slot per cycle. No arbitration is needed.
- pending_count = previous count + writes into empty slots − drains not refilled, computed every cycle.
- recv_data holds its last delivered value until the next delivery.
- Out-of-range indices cannot occur because N is a power of two.

## Timing
- Reset (reset low, asynchronous):
  - All slot_full = 0, all FSMs IDLE, recv_ready = 0, recv_data = 0.0, pending_count = 0.
  - send_ok = 1 for every core once reset state settles, since all slots are empty.
  - Reset mid-transfer discards all buffered messages.
  - Deassertion is synchronised by the integrating level; no transfer may be attempted in the first cycle after release.
- Send latency: 0 cycles to accept (send_ok combinational); the slot is visible to the receiver from the next cycle.
- Receive latency: request in cycle t with slot full → recv_ready and recv_data in cycle t+1.
- Minimum end-to-end: send at t, request at t+1, data at t+2.
- Back-to-back throughput per receiver: one message every 2 cycles.
- Back-to-back throughput per sender: one message every cycle into distinct slots, or into the same slot if it is drained each cycle.
- Full slot with no drain: send_ok = 0 and the sender stalls indefinitely. No timeout.

## Test plan
- Reset/idle:
  - Assert reset low mid-cycle → all recv_ready = 0, pending_count = 0, send_ok = 1 immediately.
  - Release, idle 5 cycles → no recv_ready pulses.
- Basic transfer:
  - Core 0 sends [1.0..16.0] to core 2 at t.
  - Core 2 requests from 0 at t+1 → recv_ready[2] = 1 at t+2 with recv_data = [1.0..16.0].
  - pending_count goes 0 → 1 → 0.
- Backpressure:
  - Core 1 sends 3.5 to core 3 twice without a drain → second attempt sees send_ok[1] = 0 and stalls.
  - Core 3 requests from 1 → stalled send is accepted in the drain cycle; core 3 gets 3.5 first, then the second message.
- Held request: core 2 holds recv_request from 0 for 6 cycles while core 0 sends every cycle → deliveries on alternate cycles only, in send order, no duplicates.
- Crossed traffic:
  - 0→1, 1→0, 2→2 (self) and 3→1 all in one cycle → all four send_ok = 1, pending_count = 4.
  - Core 1 receives from 0 then from 3, each with the correct payload.
- Async reset mid-operation: reset low while 3 slots are full and core 0 is in DELIVER → all state cleared, recv_ready drops asynchronously, and no stale delivery occurs after release.
